// File: rtl/game_ctrl.sv
// SnakeWars game sequencer: menu / clear / play / game-over phases, frame-paced
// snake step scheduling and map-clear requests, all with registered outputs.
module game_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned BTN_X0          = 448,
    parameter int unsigned BTN_X1          = 575,
    parameter int unsigned BTN_Y0          = 352,
    parameter int unsigned BTN_Y1          = 415
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_left,
    output logic        clear_req,
    input  logic        clear_done,
    output logic        step_req,
    input  logic        step_ack,
    input  logic [1:0]  collision,
    output logic [1:0]  mode,
    output logic [1:0]  winner,
    output logic [15:0] step_count
);

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_STEP  = 3'd3,
        S_END   = 3'd4
    } state_t;

    localparam logic [1:0]  MODE_MENU = 2'd0;
    localparam logic [1:0]  MODE_GAME = 2'd1;
    localparam logic [1:0]  MODE_END  = 2'd2;
    localparam logic [7:0]  FCNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [11:0] X0 = 12'(BTN_X0);
    localparam logic [11:0] X1 = 12'(BTN_X1);
    localparam logic [11:0] Y0 = 12'(BTN_Y0);
    localparam logic [11:0] Y1 = 12'(BTN_Y1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  fcnt_r;
    logic [7:0]  fcnt_nx_s;
    logic [1:0]  winner_nx_s;
    logic [15:0] step_count_nx_s;
    logic [1:0]  mode_nx_s;
    logic        clear_req_nx_s;
    logic        step_req_nx_s;
    logic        vs_prev_r;
    logic        ml_prev_r;
    logic        frame_edge_s;
    logic        click_s;
    logic        in_btn_s;

    assign frame_edge_s = vsync & ~vs_prev_r;
    assign click_s      = mouse_left & ~ml_prev_r;
    assign in_btn_s     = (mouse_x >= X0) && (mouse_x <= X1) &&
                          (mouse_y >= Y0) && (mouse_y <= Y1);

    // Edge-detector history; reset high so a level already high is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_prev_r <= 1'b1;
            ml_prev_r <= 1'b1;
        end else begin
            vs_prev_r <= vsync;
            ml_prev_r <= mouse_left;
        end
    end

    // State, frame counter and all outputs are registered from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_MENU;
            fcnt_r     <= 8'd0;
            winner     <= 2'b00;
            step_count <= 16'd0;
            mode       <= MODE_MENU;
            clear_req  <= 1'b0;
            step_req   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            fcnt_r     <= fcnt_nx_s;
            winner     <= winner_nx_s;
            step_count <= step_count_nx_s;
            mode       <= mode_nx_s;
            clear_req  <= clear_req_nx_s;
            step_req   <= step_req_nx_s;
        end
    end

    // Next-state logic; frame edges only count in S_WAIT, acks only in their requesting state.
    always_comb begin
        state_nx_s      = state_r;
        fcnt_nx_s       = fcnt_r;
        winner_nx_s     = winner;
        step_count_nx_s = step_count;
        case (state_r)
            S_MENU: begin
                if (click_s && in_btn_s) begin
                    state_nx_s      = S_CLEAR;
                    fcnt_nx_s       = 8'd0;
                    winner_nx_s     = 2'b00;
                    step_count_nx_s = 16'd0;
                end else begin
                    state_nx_s = S_MENU;
                end
            end
            S_CLEAR: begin
                if (clear_done) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_CLEAR;
                end
            end
            S_WAIT: begin
                if (frame_edge_s) begin
                    if (fcnt_r == FCNT_LAST) begin
                        state_nx_s = S_STEP;
                        fcnt_nx_s  = 8'd0;
                    end else begin
                        fcnt_nx_s = fcnt_r + 8'd1;
                    end
                end else begin
                    fcnt_nx_s = fcnt_r;
                end
            end
            S_STEP: begin
                if (step_ack) begin
                    if (step_count != 16'hFFFF) begin
                        step_count_nx_s = step_count + 16'd1;
                    end else begin
                        step_count_nx_s = step_count;
                    end
                    // A crashed player loses; both crashing is a draw.
                    case (collision)
                        2'b00: state_nx_s = S_WAIT;
                        2'b01: begin
                            winner_nx_s = 2'b10;
                            state_nx_s  = S_END;
                        end
                        2'b10: begin
                            winner_nx_s = 2'b01;
                            state_nx_s  = S_END;
                        end
                        2'b11: begin
                            winner_nx_s = 2'b11;
                            state_nx_s  = S_END;
                        end
                        default: state_nx_s = S_WAIT;
                    endcase
                end else begin
                    state_nx_s = S_STEP;
                end
            end
            S_END: begin
                if (click_s) begin
                    state_nx_s = S_MENU;
                end else begin
                    state_nx_s = S_END;
                end
            end
            default: state_nx_s = S_MENU;
        endcase
    end

    // Output decode of the next state, so registered outputs track the state register.
    always_comb begin
        mode_nx_s      = MODE_MENU;
        clear_req_nx_s = 1'b0;
        step_req_nx_s  = 1'b0;
        case (state_nx_s)
            S_MENU:  mode_nx_s = MODE_MENU;
            S_CLEAR: begin
                mode_nx_s      = MODE_GAME;
                clear_req_nx_s = 1'b1;
            end
            S_WAIT:  mode_nx_s = MODE_GAME;
            S_STEP: begin
                mode_nx_s     = MODE_GAME;
                step_req_nx_s = 1'b1;
            end
            S_END:   mode_nx_s = MODE_END;
            default: mode_nx_s = MODE_MENU;
        endcase
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected output tuples, a
// negedge monitor pops one per observed output change; a second instance checks saturation.
module tb_game_ctrl;

    typedef logic [21:0] tup_t;

    logic        clk = 1'b0;
    logic        rst, vsync, mouse_left, clear_done, step_ack;
    logic [11:0] mouse_x, mouse_y;
    logic [1:0]  collision;
    logic        clear_req, step_req;
    logic [1:0]  mode, winner;
    logic [15:0] step_count;

    logic        rst2, vsync2, mouse_left2;
    logic        clear_req2, step_req2;
    logic [1:0]  mode2, winner2;
    logic [15:0] step_count2;
    logic [11:0] mx2 = 12'd500;
    logic [11:0] my2 = 12'd380;
    logic        one2 = 1'b1;
    logic [1:0]  coll2 = 2'b00;

    int   total = 0;
    int   bad   = 0;
    tup_t exp_q[$];
    tup_t prev_tup = '0;
    tup_t mon_cur;
    tup_t mon_exp;

    logic [1:0]  e_mode, e_winner;
    logic        e_clear, e_step;
    logic [15:0] e_count;

    always #5 clk = ~clk;

    game_ctrl #(.FRAMES_PER_STEP(3)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_left(mouse_left), .clear_req(clear_req), .clear_done(clear_done),
        .step_req(step_req), .step_ack(step_ack), .collision(collision),
        .mode(mode), .winner(winner), .step_count(step_count)
    );

    game_ctrl #(.FRAMES_PER_STEP(1)) dut_sat (
        .clk(clk), .rst(rst2), .vsync(vsync2), .mouse_x(mx2), .mouse_y(my2),
        .mouse_left(mouse_left2), .clear_req(clear_req2), .clear_done(one2),
        .step_req(step_req2), .step_ack(one2), .collision(coll2),
        .mode(mode2), .winner(winner2), .step_count(step_count2)
    );

    function automatic tup_t pack(input logic [1:0] m, input logic c, input logic s,
                                  input logic [1:0] w, input logic [15:0] n);
        return {m, c, s, w, n};
    endfunction

    // Monitor: every change of the output tuple must match the next expected entry.
    always @(negedge clk) begin
        mon_cur = pack(mode, clear_req, step_req, winner, step_count);
        if (mon_cur !== prev_tup) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %h required %h", mon_cur, prev_tup);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_cur !== mon_exp) begin
                    bad++;
                    $display("FAIL out_seq: got %h required %h", mon_cur, mon_exp);
                end
            end
            prev_tup = mon_cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic push_exp();
        exp_q.push_back(pack(e_mode, e_clear, e_step, e_winner, e_count));
    endtask

    task automatic drain(input int n, input string nm);
        int k;
        k = 0;
        total++;
        while (exp_q.size() != 0 && k < n) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending changes required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic click(input logic [11:0] x, input logic [11:0] y);
        mouse_x = x;
        mouse_y = y;
        mouse_left = 1'b1;
        tick(1);
        mouse_left = 1'b0;
        tick(1);
    endtask

    task automatic frame();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic start_game();
        e_mode = 2'd1; e_clear = 1'b1; e_winner = 2'b00; e_count = 16'd0;
        push_exp();
        click(12'd500, 12'd380);
        drain(0, "start_click");
        frame();
        e_clear = 1'b0;
        push_exp();
        clear_done = 1'b1;
        tick(1);
        clear_done = 1'b0;
        tick(1);
        drain(0, "clear_done");
    endtask

    task automatic req_step();
        frame();
        frame();
        e_step = 1'b1;
        push_exp();
        frame();
        drain(0, "step_req_rise");
    endtask

    task automatic ack_step(input logic [1:0] coll, input int hold);
        e_step = 1'b0;
        if (e_count != 16'hFFFF) e_count = e_count + 16'd1;
        case (coll)
            2'b01: begin e_mode = 2'd2; e_winner = 2'b10; end
            2'b10: begin e_mode = 2'd2; e_winner = 2'b01; end
            2'b11: begin e_mode = 2'd2; e_winner = 2'b11; end
            default: e_mode = 2'd1;
        endcase
        push_exp();
        collision = coll;
        step_ack = 1'b1;
        tick(hold);
        step_ack = 1'b0;
        collision = 2'b00;
        tick(1);
        drain(0, "step_ack");
    endtask

    task automatic end_click();
        e_mode = 2'd0;
        push_exp();
        click(12'd10, 12'd10);
        drain(0, "end_click");
    endtask

    task automatic main_seq();
        rst = 1'b0; vsync = 1'b1; mouse_left = 1'b1; mouse_x = 12'd0; mouse_y = 12'd0;
        clear_done = 1'b0; step_ack = 1'b0; collision = 2'b00;
        e_mode = 2'd0; e_clear = 1'b0; e_step = 1'b0; e_winner = 2'b00; e_count = 16'd0;
        tick(3);
        chk("reset_state", 32'(pack(mode, clear_req, step_req, winner, step_count)), 32'd0);
        rst = 1'b1;
        tick(1000);
        chk("idle_after_release", {28'd0, mode, clear_req, step_req}, 32'd0);
        mouse_left = 1'b0;
        vsync = 1'b0;
        tick(2);
        click(12'd10, 12'd10);
        click(12'd447, 12'd380);
        click(12'd500, 12'd416);
        click(12'd576, 12'd352);
        tick(2);
        chk("outside_clicks_menu", {30'd0, mode}, 32'd0);

        start_game();
        req_step();
        frame();
        ack_step(2'b00, 2);
        req_step();
        frame();
        ack_step(2'b00, 1);
        req_step();
        frame();
        ack_step(2'b00, 1);
        chk("three_steps", {16'd0, step_count}, 32'd3);
        req_step();
        ack_step(2'b01, 1);
        end_click();
        chk("winner_held_p1", {30'd0, winner}, 32'd2);

        start_game();
        req_step();
        ack_step(2'b10, 1);
        end_click();
        chk("winner_held_p0", {30'd0, winner}, 32'd1);

        start_game();
        click(12'd500, 12'd380);
        clear_done = 1'b1;
        tick(1);
        clear_done = 1'b0;
        req_step();
        ack_step(2'b11, 1);
        end_click();
        chk("winner_held_draw", {30'd0, winner}, 32'd3);

        start_game();
        req_step();
        e_mode = 2'd0; e_clear = 1'b0; e_step = 1'b0; e_winner = 2'b00; e_count = 16'd0;
        push_exp();
        rst = 1'b0;
        #1;
        chk("async_reset_in_step", {28'd0, mode, clear_req, step_req}, 32'd0);
        tick(2);
        drain(0, "reset_change");
        rst = 1'b1;
        tick(2);
        start_game();
        req_step();
        ack_step(2'b00, 1);
        chk("count_after_reset", {16'd0, step_count}, 32'd1);
    endtask

    task automatic sat_seq();
        int n;
        int cyc;
        rst2 = 1'b0; vsync2 = 1'b0; mouse_left2 = 1'b0;
        tick(3);
        rst2 = 1'b1;
        tick(1);
        mouse_left2 = 1'b1;
        tick(1);
        mouse_left2 = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 65540 && cyc < 140000) begin
            @(negedge clk);
            cyc++;
            if (step_req2) begin
                if (n == 0 || n == 1 || n == 1000 || n == 65534 || n == 65535 ||
                    n == 65536 || n == 65539) begin
                    chk("sat_count", {16'd0, step_count2}, (n > 65535) ? 32'd65535 : 32'(n));
                end
                n++;
            end
            @(posedge clk);
            #1;
            vsync2 = ~vsync2;
        end
        if (n < 65540) begin
            total++;
            bad++;
            $display("FAIL sat_timeout: got %0d steps required 65540", n);
        end
        tick(2);
        chk("sat_final", {16'd0, step_count2}, 32'h0000FFFF);
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        tick(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d entries required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
